trap_sequencer: RTL and testbench

Multi-cycle controller that sequences machine-mode trap entry and `mret` return through the single CSR-file port. It owns that port, multiplexing it between the core's CSR-instruction traffic and its own save/restore writes. It also decides interrupt acceptance and priority, stalls the core while sequencing, and emits a one-cycle PC redirect to the trap vector or saved `mepc`.

---
 rtl/trap_sequencer_if.sv | 21 ++
 rtl/trap_sequencer.sv | 151 +++++++++++++++
 tb/tb_trap_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_sequencer_if.sv
// rtl/trap_sequencer_if.sv - CSR-file port shared between the trap sequencer and the CSR file
interface trap_sequencer_if;
    logic [11:0] csr_address;
    logic [31:0] csr_write_value;
    logic        csr_write_enable;
    logic [31:0] csr_read_value;

    modport master (
        output csr_address,
        output csr_write_value,
        output csr_write_enable,
        input  csr_read_value
    );

    modport slave (
        input  csr_address,
        input  csr_write_value,
        input  csr_write_enable,
        output csr_read_value
    );
endinterface

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - machine-mode trap entry / mret sequencer owning the CSR-file port
module trap_sequencer (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    boundary,
    input  logic [31:0]             pc,
    input  logic                    exception_valid,
    input  logic [30:0]             exception_code,
    input  logic                    mret_valid,
    input  logic [2:0]              irq_pending,
    input  logic [2:0]              irq_enable,
    input  logic                    global_enable,
    input  logic [11:0]             core_csr_address,
    input  logic [31:0]             core_csr_write_value,
    input  logic                    core_csr_write_enable,
    output logic                    core_csr_grant,
    trap_sequencer_if.master        csr_port,
    output logic                    stall,
    output logic                    redirect_valid,
    output logic [31:0]             redirect_pc
);
    localparam logic [11:0] MSTATUS = 12'h300;
    localparam logic [11:0] MTVEC   = 12'h305;
    localparam logic [11:0] MEPC    = 12'h341;
    localparam logic [11:0] MCAUSE  = 12'h342;

    typedef enum logic [3:0] {
        IDLE, T_EPC, T_CAUSE, T_RDSTAT, T_WRSTAT, T_RDTVEC,
        M_RDSTAT, M_WRSTAT, M_RDEPC, REDIRECT
    } state_t;

    state_t      state;
    logic [31:0] saved_pc;
    logic [31:0] saved_status;
    logic        saved_irq;
    logic [30:0] saved_code;

    logic [2:0]  active_irq;
    logic        irq_take;
    logic [30:0] irq_code;
    logic        event_hit;

    assign active_irq = irq_pending & irq_enable;
    assign irq_take   = boundary & global_enable & (|active_irq);
    // MEI outranks MSI, which outranks MTI
    assign irq_code   = active_irq[2] ? 31'd11 : (active_irq[0] ? 31'd3 : 31'd7);
    assign event_hit  = exception_valid | mret_valid | irq_take;

    always_comb begin
        core_csr_grant            = 1'b0;
        csr_port.csr_address      = 12'h000;
        csr_port.csr_write_value  = 32'h0;
        csr_port.csr_write_enable = 1'b0;
        case (state)
            IDLE: begin
                core_csr_grant            = 1'b1;
                csr_port.csr_address      = core_csr_address;
                csr_port.csr_write_value  = core_csr_write_value;
                // the instruction that raised the event must not commit its own CSR write
                csr_port.csr_write_enable = core_csr_write_enable & ~event_hit;
            end
            T_EPC: begin
                csr_port.csr_address      = MEPC;
                csr_port.csr_write_value  = saved_pc;
                csr_port.csr_write_enable = 1'b1;
            end
            T_CAUSE: begin
                csr_port.csr_address      = MCAUSE;
                csr_port.csr_write_value  = {saved_irq, saved_code};
                csr_port.csr_write_enable = 1'b1;
            end
            T_RDSTAT, M_RDSTAT: csr_port.csr_address = MSTATUS;
            T_WRSTAT: begin
                csr_port.csr_address      = MSTATUS;
                csr_port.csr_write_value  = {saved_status[31:8], saved_status[3],
                                             saved_status[6:4], 1'b0, saved_status[2:0]};
                csr_port.csr_write_enable = 1'b1;
            end
            M_WRSTAT: begin
                csr_port.csr_address      = MSTATUS;
                csr_port.csr_write_value  = {saved_status[31:8], 1'b1,
                                             saved_status[6:4], saved_status[7], saved_status[2:0]};
                csr_port.csr_write_enable = 1'b1;
            end
            T_RDTVEC: csr_port.csr_address = MTVEC;
            M_RDEPC:  csr_port.csr_address = MEPC;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            stall          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'h0;
            saved_pc       <= 32'h0;
            saved_status   <= 32'h0;
            saved_irq      <= 1'b0;
            saved_code     <= 31'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (event_hit) begin
                        saved_pc <= pc & ~32'h3;
                        stall    <= 1'b1;
                    end
                    if (exception_valid) begin
                        saved_irq  <= 1'b0;
                        saved_code <= exception_code;
                        state      <= T_EPC;
                    end else if (mret_valid) begin
                        state <= M_RDSTAT;
                    end else if (irq_take) begin
                        saved_irq  <= 1'b1;
                        saved_code <= irq_code;
                        state      <= T_EPC;
                    end
                end
                T_EPC:    state <= T_CAUSE;
                T_CAUSE:  state <= T_RDSTAT;
                T_RDSTAT: begin
                    saved_status <= csr_port.csr_read_value;
                    state        <= T_WRSTAT;
                end
                T_WRSTAT: state <= T_RDTVEC;
                T_RDTVEC: begin
                    redirect_pc    <= csr_port.csr_read_value & ~32'h3;
                    redirect_valid <= 1'b1;
                    state          <= REDIRECT;
                end
                M_RDSTAT: begin
                    saved_status <= csr_port.csr_read_value;
                    state        <= M_WRSTAT;
                end
                M_WRSTAT: state <= M_RDEPC;
                M_RDEPC: begin
                    redirect_pc    <= csr_port.csr_read_value & ~32'h3;
                    redirect_valid <= 1'b1;
                    state          <= REDIRECT;
                end
                REDIRECT: begin
                    redirect_valid <= 1'b0;
                    stall          <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - bench for trap_sequencer with transaction-level reference model
module tb_trap_sequencer;
    logic        clock = 1'b0;
    logic        reset;
    logic        boundary;
    logic [31:0] pc;
    logic        exception_valid;
    logic [30:0] exception_code;
    logic        mret_valid;
    logic [2:0]  irq_pending;
    logic [2:0]  irq_enable;
    logic        global_enable;
    logic [11:0] core_csr_address;
    logic [31:0] core_csr_write_value;
    logic        core_csr_write_enable;
    logic        core_csr_grant;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    trap_sequencer_if bus ();

    trap_sequencer dut (
        .clock                 (clock),
        .reset                 (reset),
        .boundary              (boundary),
        .pc                    (pc),
        .exception_valid       (exception_valid),
        .exception_code        (exception_code),
        .mret_valid            (mret_valid),
        .irq_pending           (irq_pending),
        .irq_enable            (irq_enable),
        .global_enable         (global_enable),
        .core_csr_address      (core_csr_address),
        .core_csr_write_value  (core_csr_write_value),
        .core_csr_write_enable (core_csr_write_enable),
        .core_csr_grant        (core_csr_grant),
        .csr_port              (bus.master),
        .stall                 (stall),
        .redirect_valid        (redirect_valid),
        .redirect_pc           (redirect_pc)
    );

    always #5 clock = ~clock;

    // CSR file environment: written only by what the DUT drives onto the port
    logic [31:0] env_csr [0:4095];
    assign bus.csr_read_value = env_csr[bus.csr_address];
    always @(posedge clock)
        if (bus.csr_write_enable) env_csr[bus.csr_address] <= bus.csr_write_value;

    int checks = 0;
    int failures = 0;
    bit checking = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reference model: expected per-cycle port activity of each pending sequence
    typedef struct {
        bit          we;
        bit          rd;
        logic [11:0] addr;
        logic [31:0] wv;
        bit          rv;
        logic [31:0] rpc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_csr [0:4095];
    logic [31:0] m_rpc;

    function automatic exp_t mk(bit we, bit rd, logic [11:0] a, logic [31:0] wv, bit rv, logic [31:0] rpc);
        exp_t e;
        e.we = we; e.rd = rd; e.addr = a; e.wv = wv; e.rv = rv; e.rpc = rpc;
        return e;
    endfunction

    always @(negedge clock) begin
        if (checking) begin
            if (exp_q.size() == 0) begin
                int          kind;
                logic [2:0]  act;
                logic [30:0] code;
                logic [31:0] s;
                act  = irq_pending & irq_enable;
                kind = 0;
                code = exception_code;
                if (exception_valid) kind = 1;
                else if (mret_valid) kind = 2;
                else if (boundary && global_enable && act != 0) begin
                    kind = 3;
                    code = act[2] ? 31'd11 : (act[0] ? 31'd3 : 31'd7);
                end
                chk("idle_grant", core_csr_grant, 1);
                chk("idle_stall", stall, 0);
                chk("idle_redirect_valid", redirect_valid, 0);
                chk("idle_redirect_pc", redirect_pc, m_rpc);
                chk("idle_addr", bus.csr_address, core_csr_address);
                chk("idle_we", bus.csr_write_enable, (core_csr_write_enable && kind == 0) ? 1 : 0);
                if (core_csr_write_enable && kind == 0) begin
                    chk("idle_wv", bus.csr_write_value, core_csr_write_value);
                    m_csr[core_csr_address] = core_csr_write_value;
                end
                if (kind == 1 || kind == 3) begin
                    s = m_csr[12'h300];
                    exp_q.push_back(mk(1, 0, 12'h341, pc & ~32'h3, 0, m_rpc));
                    exp_q.push_back(mk(1, 0, 12'h342, {(kind == 3) ? 1'b1 : 1'b0, code}, 0, m_rpc));
                    exp_q.push_back(mk(0, 1, 12'h300, 0, 0, m_rpc));
                    exp_q.push_back(mk(1, 0, 12'h300, (s & ~32'h88) | (s[3] ? 32'h80 : 32'h0), 0, m_rpc));
                    exp_q.push_back(mk(0, 1, 12'h305, 0, 0, m_rpc));
                    exp_q.push_back(mk(0, 0, 12'h000, 0, 1, m_csr[12'h305] & ~32'h3));
                end else if (kind == 2) begin
                    s = m_csr[12'h300];
                    exp_q.push_back(mk(0, 1, 12'h300, 0, 0, m_rpc));
                    exp_q.push_back(mk(1, 0, 12'h300, (s & ~32'h8) | (s[7] ? 32'h8 : 32'h0) | 32'h80, 0, m_rpc));
                    exp_q.push_back(mk(0, 1, 12'h341, 0, 0, m_rpc));
                    exp_q.push_back(mk(0, 0, 12'h000, 0, 1, m_csr[12'h341] & ~32'h3));
                end
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("seq_grant", core_csr_grant, 0);
                chk("seq_stall", stall, 1);
                chk("seq_we", bus.csr_write_enable, e.we ? 1 : 0);
                chk("seq_wv", bus.csr_write_value, e.wv);
                if (e.we || e.rd) chk("seq_addr", bus.csr_address, e.addr);
                chk("seq_redirect_valid", redirect_valid, e.rv ? 1 : 0);
                chk("seq_redirect_pc", redirect_pc, e.rpc);
                if (e.we) m_csr[e.addr] = e.wv;
                m_rpc = e.rpc;
            end
            if (reset) begin
                exp_q.delete();
                m_rpc = 32'h0;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        boundary = 0; pc = 0; exception_valid = 0; exception_code = 0; mret_valid = 0;
        irq_pending = 0; irq_enable = 0; global_enable = 0;
        core_csr_address = 0; core_csr_write_value = 0; core_csr_write_enable = 0;
    endtask

    task automatic set_csr(logic [11:0] a, logic [31:0] v);
        env_csr[a] = v;
        m_csr[a] = v;
    endtask

    // Event inputs are already set for cycle N; returns the cycle offset of the redirect pulse
    task automatic run_event(output int lat, output logic [31:0] rpc);
        lat = -1;
        rpc = 32'h0;
        step();
        quiet();
        for (int k = 1; k <= 12; k++) begin
            if (redirect_valid && lat < 0) begin
                lat = k;
                rpc = redirect_pc;
            end
            step();
        end
    endtask

    int          lat;
    logic [31:0] rpc_seen;
    int          cnt;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            env_csr[i] = 32'h0;
            m_csr[i] = 32'h0;
        end
        m_rpc = 32'h0;
        quiet();
        reset = 1;
        step();
        step();
        reset = 0;
        chk("reset_stall", stall, 0);
        chk("reset_redirect_valid", redirect_valid, 0);
        chk("reset_redirect_pc", redirect_pc, 32'h0);
        chk("reset_grant", core_csr_grant, 1);
        checking = 1;

        // exception entry
        set_csr(12'h305, 32'h0000_0100);
        set_csr(12'h300, 32'h0000_1888);
        pc = 32'h0000_1004; exception_valid = 1; exception_code = 31'd2;
        run_event(lat, rpc_seen);
        chk("exc_latency", lat, 6);
        chk("exc_redirect_pc", rpc_seen, 32'h0000_0100);
        chk("exc_mepc", env_csr[12'h341], 32'h0000_1004);
        chk("exc_mcause", env_csr[12'h342], 32'h0000_0002);
        chk("exc_mstatus", env_csr[12'h300], 32'h0000_1880);

        // interrupt priority
        for (int t = 0; t < 3; t++) begin
            logic [2:0]  pend_tab [3];
            logic [31:0] cause_tab [3];
            pend_tab  = '{3'b111, 3'b011, 3'b010};
            cause_tab = '{32'h8000_000B, 32'h8000_0003, 32'h8000_0007};
            boundary = 1; global_enable = 1; irq_enable = 3'b111; irq_pending = pend_tab[t];
            pc = 32'h0000_3002;
            run_event(lat, rpc_seen);
            chk("irq_latency", lat, 6);
            chk("irq_mcause", env_csr[12'h342], cause_tab[t]);
            chk("irq_mepc", env_csr[12'h341], 32'h0000_3000);
        end

        // masking: global off, meie off, boundary off
        for (int t = 0; t < 3; t++) begin
            quiet();
            irq_pending = 3'b100;
            irq_enable = (t == 1) ? 3'b011 : 3'b111;
            global_enable = (t == 0) ? 1'b0 : 1'b1;
            boundary = (t == 2) ? 1'b0 : 1'b1;
            cnt = 0;
            for (int k = 0; k < 20; k++) begin
                if (stall || bus.csr_write_enable) cnt++;
                step();
            end
            chk("mask_activity", cnt, 0);
        end
        quiet();

        // mret
        set_csr(12'h300, 32'h0000_1880);
        set_csr(12'h341, 32'h0000_2000);
        mret_valid = 1;
        run_event(lat, rpc_seen);
        chk("mret_latency", lat, 4);
        chk("mret_redirect_pc", rpc_seen, 32'h0000_2000);
        chk("mret_mstatus", env_csr[12'h300], 32'h0000_1888);

        // arbitration
        core_csr_address = 12'h340; core_csr_write_value = 32'hDEAD_BEEF; core_csr_write_enable = 1;
        #1;
        chk("arb_idle_grant", core_csr_grant, 1);
        step();
        quiet();
        chk("arb_idle_write", env_csr[12'h340], 32'hDEAD_BEEF);
        set_csr(12'h340, 32'h0);
        core_csr_address = 12'h340; core_csr_write_value = 32'hDEAD_BEEF; core_csr_write_enable = 1;
        exception_valid = 1; exception_code = 31'd5; pc = 32'h0000_4000;
        run_event(lat, rpc_seen);
        chk("arb_suppressed", env_csr[12'h340], 32'h0);
        exception_valid = 1; exception_code = 31'd7; pc = 32'h0000_5000;
        step();
        quiet();
        step();
        core_csr_address = 12'h340; core_csr_write_value = 32'h1234_5678; core_csr_write_enable = 1;
        #1;
        chk("arb_tcause_grant", core_csr_grant, 0);
        step();
        quiet();
        for (int k = 0; k < 8; k++) step();
        chk("arb_tcause_ignored", env_csr[12'h340], 32'h0);

        // reset during T_RDSTAT
        set_csr(12'h300, 32'h0000_1888);
        exception_valid = 1; exception_code = 31'd3; pc = 32'h0000_6000;
        step();
        quiet();
        step();
        step();
        reset = 1;
        step();
        reset = 0;
        chk("rst_mid_grant", core_csr_grant, 1);
        chk("rst_mid_stall", stall, 0);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (redirect_valid) cnt++;
            step();
        end
        chk("rst_mid_no_redirect", cnt, 0);
        chk("rst_mid_mstatus", env_csr[12'h300], 32'h0000_1888);

        // randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            logic [11:0] addr_tab [6];
            addr_tab = '{12'h340, 12'h300, 12'h305, 12'h341, 12'h342, 12'h7C0};
            reset                 = ($urandom_range(0, 299) == 0);
            boundary              = $urandom_range(0, 1);
            pc                    = $urandom;
            exception_valid       = ($urandom_range(0, 15) == 0);
            exception_code        = 31'($urandom);
            mret_valid            = ($urandom_range(0, 11) == 0);
            irq_pending           = 3'($urandom);
            irq_enable            = 3'($urandom);
            global_enable         = ($urandom_range(0, 3) == 0);
            core_csr_address      = addr_tab[$urandom_range(0, 5)];
            core_csr_write_value  = $urandom;
            core_csr_write_enable = $urandom_range(0, 1);
            step();
        end
        reset = 0;
        quiet();
        for (int k = 0; k < 10; k++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
